// File: rtl/spi_multiplier_param.sv
// SPI-slave multiplier: receives {MODE, A, B} MSB first, multiplies with a
// sequential shift-add unit, then returns the 2*WIDTH-bit product on MISO.
module spi_multiplier_param #(
  parameter int WIDTH = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CS,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  output logic BUSY
);

  localparam int PW = 2 * WIDTH;
  localparam int FW = PW + 1;
  localparam int CW = $clog2(FW + 1);
  localparam logic [CW-1:0] LAST_RX   = CW'(PW);
  localparam logic [CW-1:0] LAST_STEP = CW'(PW - 1);

  typedef enum logic [2:0] {IDLE, RX, CALC, TX, DONE} state_t;

  state_t          state_q;
  logic [1:0]      cs_sync_q;
  logic [1:0]      mosi_sync_q;
  logic [2:0]      sclk_sync_q;
  logic [PW-1:0]   frame_q;
  logic [PW-1:0]   mcand_q;
  logic [PW-1:0]   mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            miso_q;
  logic            busy_q;

  logic            cs_s;
  logic            mosi_s;
  logic            sclk_rise;
  logic            sclk_fall;
  logic [FW-1:0]   frame_full;
  logic [PW-1:0]   acc_d;

  function automatic logic [PW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return sgn ? {{WIDTH{v[WIDTH-1]}}, v} : {{WIDTH{1'b0}}, v};
  endfunction

  assign cs_s       = cs_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign frame_full = {frame_q, mosi_s};
  assign acc_d      = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign MISO       = miso_q;
  assign BUSY       = busy_q;

  // Input synchronisers; the third SCLK flop gives edge history
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], CS};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      frame_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          frame_q <= '0;
          if (cs_s) state_q <= RX;
        end
        RX: begin
          if (!cs_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (sclk_rise) begin
            frame_q <= frame_full[PW-1:0];
            if (cnt_q == LAST_RX) begin
              mcand_q  <= extend(frame_full[PW-1:WIDTH], frame_full[PW]);
              mplier_q <= extend(frame_full[WIDTH-1:0], frame_full[PW]);
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= CALC;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        CALC: begin
          if (!cs_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == LAST_STEP) begin
              // Low 2W bits of the extended product are exact in both modes
              miso_q  <= acc_d[PW-1];
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= TX;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        TX: begin
          if (!cs_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (sclk_fall) begin
            if (cnt_q == LAST_STEP) begin
              miso_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              acc_q  <= acc_q << 1;
              miso_q <= acc_q[PW-2];
              cnt_q  <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          if (!cs_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
